// File: rtl/tile_pkg.sv
// Shared constants for the tile-map pixel renderer: tile-word field layout,
// RGB333 colours, default palette table and glyph content generator.
package tile_pkg;

    // Default geometry; the top module exposes these as overridable parameters.
    localparam int TILE_WIDTH_DEF   = 32;
    localparam int TILE_HEIGHT_DEF  = 32;
    localparam int GRID_COLS_DEF    = 20;
    localparam int GRID_ROWS_DEF    = 15;
    localparam int TILE_ID_BITS_DEF = 4;
    localparam int PIXEL_BITS_DEF   = 9;

    localparam int TILE_W_LOG2 = $clog2(TILE_WIDTH_DEF);
    localparam int TILE_H_LOG2 = $clog2(TILE_HEIGHT_DEF);
    localparam int MAP_ADDR_W  = $clog2(GRID_COLS_DEF * GRID_ROWS_DEF);
    localparam int COORD_W     = 10;
    localparam int PAL_ENTRIES = 16;

    // Tile word bit fields.
    localparam int ID_LSB    = 0;
    localparam int ID_MSB    = 3;
    localparam int HFLIP_BIT = 4;
    localparam int VFLIP_BIT = 5;
    localparam int PAL_LSB   = 6;
    localparam int PAL_MSB   = 7;

    // RGB333 colours.
    localparam logic [8:0] RGB_BLACK   = 9'b000_000_000;
    localparam logic [8:0] RGB_BG_BLUE = 9'b000_000_111;

    // Reset contents of palette entry n: R = pal+1, G = B = index.
    // Index 0 of every palette is the background colour.
    function automatic logic [8:0] default_pal_entry(input logic [3:0] n, input logic [8:0] bg);
        logic [2:0] r_s;
        logic [2:0] g_s;
        logic [2:0] b_s;
        logic [8:0] e_s;
        r_s = {1'b0, n[3:2]} + 3'd1;
        g_s = {1'b0, n[1:0]};
        b_s = {1'b0, n[1:0]};
        if (n[1:0] == 2'b00) begin
            e_s = bg;
        end else begin
            e_s = {r_s, g_s, b_s};
        end
        return e_s;
    endfunction

    // Glyph artwork: 2-bit colour index of texel (gx, gy) in glyph id.
    // Defined arithmetically so the ROM needs no external image file.
    function automatic logic [1:0] glyph_texel(input logic [31:0] id, input logic [31:0] gy,
                                               input logic [31:0] gx);
        logic [31:0] t_s;
        t_s = (gx * gy) + id;
        return t_s[1:0];
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// Synchronous-read 2-bpp glyph ROM addressed by {id, gy, gx}.
module glyph_rom
    import tile_pkg::*;
#(
    parameter int ID_BITS = TILE_ID_BITS_DEF,
    parameter int GY_BITS = TILE_H_LOG2,
    parameter int GX_BITS = TILE_W_LOG2,
    localparam int ADDR_W = ID_BITS + GY_BITS + GX_BITS
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [1:0]        data_o
);

    logic [1:0] data_q;

    // Registered texel read; cleared with the rest of the pipeline.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= 2'b00;
        end else begin
            data_q <= glyph_texel(32'(addr_i[ADDR_W-1 -: ID_BITS]),
                                  32'(addr_i[GX_BITS +: GY_BITS]),
                                  32'(addr_i[GX_BITS-1:0]));
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/tile_pixel_renderer.sv
// Tile-map renderer: screen coordinate -> tile-map fetch -> glyph texel with
// flips -> runtime palette -> RGB333 pixel, three cycles later.
module tile_pixel_renderer
    import tile_pkg::*;
#(
    parameter int TILE_WIDTH   = TILE_WIDTH_DEF,
    parameter int TILE_HEIGHT  = TILE_HEIGHT_DEF,
    parameter int GRID_COLS    = GRID_COLS_DEF,
    parameter int GRID_ROWS    = GRID_ROWS_DEF,
    parameter int TILE_ID_BITS = TILE_ID_BITS_DEF,
    parameter int PIXEL_BITS   = PIXEL_BITS_DEF,
    parameter logic [PIXEL_BITS-1:0] BG_COLOR = PIXEL_BITS'(RGB_BG_BLUE),
    localparam int MAP_AW = $clog2(GRID_COLS * GRID_ROWS)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [COORD_W-1:0]    i_Col,
    input  logic [COORD_W-1:0]    i_Row,
    input  logic                  i_Active,
    output logic [MAP_AW-1:0]     o_Map_Addr,
    input  logic [7:0]            i_Map_Data,
    input  logic                  i_Pal_We,
    input  logic [3:0]            i_Pal_Addr,
    input  logic [PIXEL_BITS-1:0] i_Pal_Data,
    output logic [PIXEL_BITS-1:0] o_Pixel,
    output logic                  o_Pixel_Valid
);

    localparam int TW_LOG2 = $clog2(TILE_WIDTH);
    localparam int TH_LOG2 = $clog2(TILE_HEIGHT);
    localparam int TX_W    = COORD_W - TW_LOG2;
    localparam int TY_W    = COORD_W - TH_LOG2;

    // ---------------- stage 1: tile coordinates and map address ----------
    logic [TX_W-1:0]    tx_s;
    logic [TY_W-1:0]    ty_s;
    logic               in_grid_s;
    logic [MAP_AW-1:0]  map_lin_s;
    logic [MAP_AW-1:0]  map_addr_d;
    logic [MAP_AW-1:0]  map_addr_q;
    logic [TW_LOG2-1:0] lx_q;
    logic [TH_LOG2-1:0] ly_q;
    logic               act1_q;
    logic               grid1_q;

    assign tx_s      = i_Col[COORD_W-1:TW_LOG2];
    assign ty_s      = i_Row[COORD_W-1:TH_LOG2];
    assign in_grid_s = (int'(tx_s) < GRID_COLS) && (int'(ty_s) < GRID_ROWS);
    assign map_lin_s = (MAP_AW'(ty_s) * MAP_AW'(GRID_COLS)) + MAP_AW'(tx_s);

    // Next map address: only in-grid coordinates update it, so it never leaves the map.
    always_comb begin
        map_addr_d = map_addr_q;
        if (in_grid_s) begin
            map_addr_d = map_lin_s;
        end else begin
            map_addr_d = map_addr_q;
        end
    end

    // ---------------- stage 2: glyph addressing with flips ----------------
    logic [TILE_ID_BITS-1:0] id_s;
    logic [TW_LOG2-1:0]      gx_s;
    logic [TH_LOG2-1:0]      gy_s;
    logic [1:0]              texel_s;
    logic [1:0]              pal2_q;
    logic                    act2_q;
    logic                    grid2_q;

    assign id_s = TILE_ID_BITS'(i_Map_Data[ID_MSB:ID_LSB]);

    // Mirror local coordinates; TILE-1-l equals ~l because tile sizes are powers of two.
    always_comb begin
        gx_s = lx_q;
        gy_s = ly_q;
        if (i_Map_Data[HFLIP_BIT]) begin
            gx_s = ~lx_q;
        end else begin
            gx_s = lx_q;
        end
        if (i_Map_Data[VFLIP_BIT]) begin
            gy_s = ~ly_q;
        end else begin
            gy_s = ly_q;
        end
    end

    glyph_rom #(
        .ID_BITS (TILE_ID_BITS),
        .GY_BITS (TH_LOG2),
        .GX_BITS (TW_LOG2)
    ) u_glyph_rom (
        .clk_i   (i_Clk),
        .rst_n_i (i_Rst_n),
        .addr_i  ({id_s, gy_s, gx_s}),
        .data_o  (texel_s)
    );

    // ---------------- stage 3: palette resolve ----------------------------
    logic [PIXEL_BITS-1:0] palette_q [PAL_ENTRIES];
    logic [PIXEL_BITS-1:0] pixel_d;
    logic [PIXEL_BITS-1:0] pixel_q;
    logic                  valid_q;

    // Output colour: black when blanked, background off-grid or for index 0.
    always_comb begin
        pixel_d = PIXEL_BITS'(RGB_BLACK);
        if (!act2_q) begin
            pixel_d = PIXEL_BITS'(RGB_BLACK);
        end else if (!grid2_q || (texel_s == 2'b00)) begin
            pixel_d = BG_COLOR;
        end else begin
            pixel_d = palette_q[{pal2_q, texel_s}];
        end
    end

    // Pipeline registers for all three stages.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            map_addr_q <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            act1_q     <= 1'b0;
            grid1_q    <= 1'b0;
            pal2_q     <= 2'b00;
            act2_q     <= 1'b0;
            grid2_q    <= 1'b0;
            pixel_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            map_addr_q <= map_addr_d;
            lx_q       <= i_Col[TW_LOG2-1:0];
            ly_q       <= i_Row[TH_LOG2-1:0];
            act1_q     <= i_Active;
            grid1_q    <= in_grid_s;
            pal2_q     <= i_Map_Data[PAL_MSB:PAL_LSB];
            act2_q     <= act1_q;
            grid2_q    <= grid1_q;
            pixel_q    <= pixel_d;
            valid_q    <= act2_q;
        end
    end

    // Palette register file; a write lands at the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int n = 0; n < PAL_ENTRIES; n++) begin
                palette_q[n] <= PIXEL_BITS'(default_pal_entry(4'(n), 9'(BG_COLOR)));
            end
        end else if (i_Pal_We) begin
            palette_q[i_Pal_Addr] <= i_Pal_Data;
        end else begin
            palette_q <= palette_q;
        end
    end

    assign o_Map_Addr    = map_addr_q;
    assign o_Pixel       = pixel_q;
    assign o_Pixel_Valid = valid_q;

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Randomized self-checking bench for tile_pixel_renderer with a behavioural
// reference model (tile map, glyph artwork, palette, 3-deep latency history).
module tb_tile_pixel_renderer;
    import tile_pkg::*;

    localparam logic [8:0] BG = 9'b000_000_111;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [9:0]            col;
    logic [9:0]            row;
    logic                  active;
    logic [MAP_ADDR_W-1:0] map_addr;
    logic [7:0]            map_data;
    logic                  pal_we;
    logic [3:0]            pal_addr;
    logic [8:0]            pal_data;
    logic [8:0]            pixel;
    logic                  pix_valid;

    logic [7:0] map_mem [300];
    logic [8:0] pal_m   [16];
    int h_act [2];
    int h_col [2];
    int h_row [2];
    int exp_addr;
    int n_checks = 0;
    int n_pass = 0;
    int vcount;

    always #20 clk = ~clk;

    // External tile-map RAM: word for the registered address.
    assign map_data = (map_addr < MAP_ADDR_W'(300)) ? map_mem[map_addr] : 8'h00;

    tile_pixel_renderer dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Col         (col),
        .i_Row         (row),
        .i_Active      (active),
        .o_Map_Addr    (map_addr),
        .i_Map_Data    (map_data),
        .i_Pal_We      (pal_we),
        .i_Pal_Addr    (pal_addr),
        .i_Pal_Data    (pal_data),
        .o_Pixel       (pixel),
        .o_Pixel_Valid (pix_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic init_pal_model();
        for (int n = 0; n < 16; n++) begin
            if (n % 4 == 0) pal_m[n] = BG;
            else pal_m[n] = 9'(((n / 4) + 1) * 64 + (n % 4) * 8 + (n % 4));
        end
    endtask

    // Reference: colour for a coordinate given current map and palette model.
    function automatic logic [8:0] expected_pixel(input int act, input int c, input int r);
        int tx, ty, w, id, hf, vf, pal, lx, ly, gx, gy, idx;
        if (act == 0) return 9'd0;
        tx = c / 32;
        ty = r / 32;
        if (tx >= 20 || ty >= 15) return BG;
        w   = int'(map_mem[ty * 20 + tx]);
        id  = w % 16;
        hf  = (w / 16) % 2;
        vf  = (w / 32) % 2;
        pal = w / 64;
        lx  = c % 32;
        ly  = r % 32;
        gx  = (hf != 0) ? 31 - lx : lx;
        gy  = (vf != 0) ? 31 - ly : ly;
        idx = (gx * gy + id) % 4;
        if (idx == 0) return BG;
        return pal_m[pal * 4 + idx];
    endfunction

    // One clock: drive at negedge, predict, check after the posedge, return at negedge.
    task automatic step(input int act, input int c, input int r, input int we, input int pa, input int pd);
        logic [8:0] e_pix;
        int e_val, tx, ty;
        active   = (act != 0);
        col      = 10'(c);
        row      = 10'(r);
        pal_we   = (we != 0);
        pal_addr = 4'(pa);
        pal_data = 9'(pd);
        e_pix = expected_pixel(h_act[1], h_col[1], h_row[1]);
        e_val = h_act[1];
        tx = c / 32;
        ty = r / 32;
        if (tx < 20 && ty < 15) exp_addr = ty * 20 + tx;
        if (we != 0) pal_m[pa] = 9'(pd);
        h_act[1] = h_act[0]; h_col[1] = h_col[0]; h_row[1] = h_row[0];
        h_act[0] = (act != 0) ? 1 : 0; h_col[0] = c; h_row[0] = r;
        @(posedge clk);
        #1;
        check("pixel", 32'(pixel), 32'(e_pix));
        check("valid", 32'(pix_valid), 32'(e_val));
        check("map_addr", 32'(map_addr), 32'(exp_addr));
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n  = 1'b0;
        active = 1'b1;
        col    = 10'd33;
        row    = 10'd65;
        pal_we = 1'b0;
        #1;
        check("rst_async_pixel", 32'(pixel), 32'd0);
        check("rst_async_valid", 32'(pix_valid), 32'd0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_pixel", 32'(pixel), 32'd0);
            check("rst_valid", 32'(pix_valid), 32'd0);
            check("rst_addr", 32'(map_addr), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            h_act[i] = 0; h_col[i] = 0; h_row[i] = 0;
        end
        exp_addr = 0;
        init_pal_model();
    endtask

    initial begin
        active = 1'b1; col = 10'd33; row = 10'd65;
        pal_we = 1'b0; pal_addr = 4'd0; pal_data = 9'd0;
        for (int i = 0; i < 300; i++) map_mem[i] = 8'($urandom_range(0, 255));
        map_mem[41] = 8'h01;
        @(negedge clk);
        do_reset(3);

        // Latency and addressing: texel (1,1) of glyph 1 is index 2, palette 0.
        step(1, 33, 65, 0, 0, 0);
        check("lat_addr", 32'(map_addr), 32'd41);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("lat_pixel", 32'(pixel), 32'(9'b001_010_010));

        // Both flips: (32,64) reads texel (31,31) of glyph 2 -> index 3.
        map_mem[41] = 8'h32;
        step(1, 32, 64, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("flip_pixel", 32'(pixel), 32'(9'b001_011_011));

        // Transparent texel (0,0) of glyph 0 on palette 3.
        map_mem[41] = 8'hC0;
        step(1, 32, 64, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("transparent", 32'(pixel), 32'(BG));

        // Bottom-right screen corner is inside the grid.
        step(1, 639, 479, 0, 0, 0);
        check("corner_addr", 32'(map_addr), 32'd299);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Palette write colliding with a lookup of entry 6.
        map_mem[41] = 8'h41;
        step(1, 33, 65, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 6, 9'b111_111_000);
        check("palwr_old", 32'(pixel), 32'(9'b010_010_010));
        step(1, 33, 65, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("palwr_new", 32'(pixel), 32'(9'b111_111_000));

        // Continuous scan of one full line.
        begin
            int r;
            r = $urandom_range(0, 479);
            vcount = 0;
            for (int c = 0; c < 640; c++) begin
                step(1, c, r, 0, 0, 0);
                if (pix_valid) vcount++;
            end
            for (int i = 0; i < 3; i++) begin
                step(0, 0, 0, 0, 0, 0);
                if (pix_valid) vcount++;
            end
            check("scan_valid_run", 32'(vcount), 32'd640);
        end

        // Reset in the middle of a line flushes the pipeline.
        for (int c = 0; c < 100; c++) step(1, c, 200, 0, 0, 0);
        do_reset(2);
        for (int c = 0; c < 6; c++) step(1, 300 + c, 100, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Randomized traffic including off-grid coordinates and palette writes.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 511)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
